iob_uart_bridge: RTL and testbench

Serial-to-bus bridge and bus initiator: a host on the far end of an RS232 link reads and writes the SoC's memory-mapped space over the same 8N1 line format the UART peripheral serves. The block deserializes command frames from `rxd`, issues one IOb-native master transaction per frame, and serializes the response on `txd`. It sits beside the CPU as a second bus master, typically behind the interconnect arbiter, for boot loading and debug.

---
 rtl/iob_uart_bridge_pkg.sv | 12 +
 rtl/iob_uart_bridge_phy.sv | 130 +++++++++++++
 rtl/iob_uart_bridge.sv | 118 +++++++++++
 tb/tb_iob_uart_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_uart_bridge_pkg.sv
// iob_uart_bridge_pkg: shared codes, state encodings and width helpers for the UART bus bridge
package iob_uart_bridge_pkg;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_t;
  function automatic logic [7:0] nbytes(input int w);
    return 8'(w / 8);
  endfunction
endpackage

// File: rtl/iob_uart_bridge_phy.sv
// iob_uart_bridge_phy: 8N1 bit-level receiver and transmitter with byte handshakes
module iob_uart_bridge_phy
  import iob_uart_bridge_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] bit_duration,
  input  logic             rxd,
  output logic             txd,
  input  logic             cts,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             frame_err,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             tx_done
);
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_t rx_st_q, rx_st_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_bd_q, rx_bd_d;
  logic [3:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic rx_valid_q, rx_valid_d, ferr_q, ferr_d;
  logic tx_busy_q, tx_busy_d;
  logic [9:0] tx_sh_q, tx_sh_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_bd_q, tx_bd_d;
  logic [3:0] tx_bit_q, tx_bit_d;

  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bd_d = rx_bd_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_valid_d = 1'b0;
    ferr_d = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (rx_s3_q && !rx_s2_q) begin
        rx_st_d = RX_START;
        rx_cnt_d = 1;
        rx_bd_d = bit_duration;
      end
      RX_START: if (rx_cnt_q == (rx_bd_q >> 1)) begin
        rx_st_d = rx_s2_q ? RX_IDLE : RX_BITS;
        rx_cnt_d = 1;
        rx_bit_d = 4'd0;
      end
      RX_BITS: if (rx_cnt_q == rx_bd_q) begin
        rx_cnt_d = 1;
        rx_bit_d = rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd8) begin
          rx_st_d = RX_IDLE;
          rx_valid_d = rx_s2_q;
          ferr_d = !rx_s2_q;
        end else
          rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // A new byte may be loaded in the last cycle of the previous stop bit, keeping bytes back-to-back
  assign tx_done  = tx_busy_q && tx_bit_q == 4'd9 && tx_cnt_q == tx_bd_q;
  assign tx_ready = cts && (!tx_busy_q || tx_done);

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_sh_d = tx_sh_q;
    tx_cnt_d = tx_cnt_q + 1'b1;
    tx_bd_d = tx_bd_q;
    tx_bit_d = tx_bit_q;
    if (tx_busy_q && tx_cnt_q == tx_bd_q) begin
      tx_cnt_d = 1;
      tx_bit_d = tx_bit_q + 4'd1;
      tx_sh_d = {1'b1, tx_sh_q[9:1]};
      tx_busy_d = tx_bit_q != 4'd9;
    end
    if (tx_valid && tx_ready) begin
      tx_busy_d = 1'b1;
      tx_sh_d = {1'b1, tx_data, 1'b0};
      tx_bd_d = bit_duration;
      tx_cnt_d = 1;
      tx_bit_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
      rx_st_q <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bd_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_valid_q <= 1'b0;
      ferr_q <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_sh_q <= '1;
      tx_cnt_q <= '0;
      tx_bd_q <= '0;
      tx_bit_q <= '0;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bd_q <= rx_bd_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      ferr_q <= ferr_d;
      tx_busy_q <= tx_busy_d;
      tx_sh_q <= tx_sh_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bd_q <= tx_bd_d;
      tx_bit_q <= tx_bit_d;
    end
  end

  assign txd       = tx_busy_q ? tx_sh_q[0] : 1'b1;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_sh_q;
  assign frame_err = ferr_q;
endmodule

// File: rtl/iob_uart_bridge.sv
// iob_uart_bridge: serial command frames from a host turned into IOb master transactions
module iob_uart_bridge
  import iob_uart_bridge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DIV_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIV_W-1:0]    bit_duration,
  input  logic                rxd,
  output logic                txd,
  input  logic                cts,
  output logic                rts,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                frame_err
);
  localparam logic [7:0] ADDR_BYTES = nbytes(ADDR_W);
  localparam logic [7:0] DATA_BYTES = nbytes(DATA_W);

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, resp_q, resp_d, resp_sel;
  logic is_rd_q, is_rd_d, rts_q, rts_d, accepting;
  logic rx_valid, tx_valid, tx_ready, tx_done;
  logic [7:0] rx_data, tx_data;

  iob_uart_bridge_phy #(.DIV_W(DIV_W)) u_phy (
    .clk(clk), .rst(rst), .bit_duration(bit_duration), .rxd(rxd), .txd(txd), .cts(cts),
    .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    resp_d = resp_q;
    is_rd_d = is_rd_q;
    resp_sel = resp_q >> {cnt_q, 3'b000};
    tx_valid = 1'b0;
    tx_data = resp_sel[7:0];
    case (state_q)
      S_IDLE: if (rx_valid) begin
        is_rd_d = rx_data == CMD_RD;
        cnt_d = 8'd0;
        len_d = 8'd1;
        resp_d = DATA_W'(NAK);
        state_d = (rx_data == CMD_WR || rx_data == CMD_RD) ? S_ADDR : S_RESP;
      end
      S_ADDR: if (rx_valid) begin
        addr_d = ADDR_W'({rx_data, addr_q} >> 8);
        cnt_d = cnt_q == ADDR_BYTES - 8'd1 ? 8'd0 : cnt_q + 8'd1;
        if (cnt_q == ADDR_BYTES - 8'd1) state_d = is_rd_q ? S_BUS : S_DATA;
      end
      S_DATA: if (rx_valid) begin
        wdata_d = DATA_W'({rx_data, wdata_q} >> 8);
        cnt_d = cnt_q == DATA_BYTES - 8'd1 ? 8'd0 : cnt_q + 8'd1;
        if (cnt_q == DATA_BYTES - 8'd1) state_d = S_BUS;
      end
      // First response byte is offered straight from m_rdata so it can start the next cycle
      S_BUS: if (m_ready) begin
        resp_d = is_rd_q ? m_rdata : DATA_W'(ACK);
        len_d = is_rd_q ? DATA_BYTES : 8'd1;
        tx_valid = 1'b1;
        tx_data = is_rd_q ? m_rdata[7:0] : ACK;
        cnt_d = {7'd0, tx_ready};
        state_d = S_RESP;
      end
      S_RESP: begin
        tx_valid = cnt_q < len_q;
        if (tx_valid && tx_ready) cnt_d = cnt_q + 8'd1;
        if (cnt_q == len_q && tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    accepting = state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA;
    if (frame_err && accepting) state_d = S_IDLE;
    rts_d = state_d == S_IDLE || state_d == S_ADDR || state_d == S_DATA;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      len_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_q <= '0;
      is_rd_q <= 1'b0;
      rts_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      resp_q <= resp_d;
      is_rd_q <= is_rd_d;
      rts_q <= rts_d;
    end
  end

  assign m_valid   = state_q == S_BUS;
  assign m_address = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = {(DATA_W/8){m_valid && !is_rd_q}};
  assign rts       = rts_q;
endmodule

// File: tb/tb_iob_uart_bridge.sv
// tb_iob_uart_bridge: directed frame-level checks of the UART bus bridge at bit_duration 8
module tb_iob_uart_bridge;
  logic clk = 1'b0, rst = 1'b0, rxd = 1'b1, cts = 1'b1, m_ready = 1'b0;
  logic [15:0] bit_duration = 16'd8;
  logic [31:0] m_rdata = '0;
  logic txd, rts, m_valid, frame_err;
  logic [31:0] m_address, m_wdata;
  logic [3:0] m_wstrb;
  int cyc = 0, mv_rises = 0, ferr_cnt = 0;
  logic mv_prev = 1'b0;
  int vectors = 0, miscompares = 0;

  iob_uart_bridge dut (
    .clk(clk), .rst(rst), .bit_duration(bit_duration), .rxd(rxd), .txd(txd), .cts(cts), .rts(rts),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mv_prev <= m_valid;
    if (m_valid && !mv_prev) mv_rises <= mv_rises + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(8);
    end
    rxd = stop;
    tick(8);
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_mv(output logic ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 5000) begin
      tick(1);
      ok = m_valid;
      n++;
    end
  endtask

  task automatic recv_byte(output logic [7:0] b, output int t);
    int n;
    b = 'x;
    t = -1;
    n = 0;
    while (txd !== 1'b0 && n < 3000) begin
      tick(1);
      n++;
    end
    if (txd === 1'b0) begin
      t = cyc;
      tick(4);
      for (int i = 0; i < 8; i++) begin
        tick(8);
        b[i] = txd;
      end
      tick(8);
      if (txd !== 1'b1) b = 'x;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b want 1", txd); end
    vectors++; if (rts !== 1'b0) begin miscompares++; $display("FAIL reset_rts: got %b want 0", rts); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mvalid: got %b want 0", m_valid); end
    vectors++; if (m_address !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", m_address); end
    vectors++; if (m_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", m_wdata); end
    vectors++; if (m_wstrb !== 4'h0) begin miscompares++; $display("FAIL reset_wstrb: got %h want 0", m_wstrb); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    rst = 1'b1;
    tick(1);
    vectors++; if (rts !== 1'b1) begin miscompares++; $display("FAIL reset_rts_rise: got %b want 1", rts); end
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    logic [7:0] b;
    int t, mv0;
    mv0 = mv_rises;
    fork
      begin send_byte(8'h01, 1'b1); send_word(a); send_word(d); end
      begin
        wait_mv(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wr_mvalid: got %b want 1", ok); end
        vectors++; if (m_address !== a) begin miscompares++; $display("FAIL wr_addr: got %h want %h", m_address, a); end
        vectors++; if (m_wdata !== d) begin miscompares++; $display("FAIL wr_wdata: got %h want %h", m_wdata, d); end
        vectors++; if (m_wstrb !== 4'hF) begin miscompares++; $display("FAIL wr_wstrb: got %h want f", m_wstrb); end
        vectors++; if (rts !== 1'b0) begin miscompares++; $display("FAIL wr_rts_bus: got %b want 0", rts); end
        tick(2);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL wr_mvalid_fall: got %b want 0", m_valid); end
        vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL wr_start_bit: got %b want 0", txd); end
        recv_byte(b, t);
        vectors++; if (b !== 8'h06) begin miscompares++; $display("FAIL wr_ack: got %h want 06", b); end
      end
    join
    tick(10);
    vectors++; if (mv_rises - mv0 !== 1) begin miscompares++; $display("FAIL wr_txn_count: got %0d want 1", mv_rises - mv0); end
  endtask

  task automatic test_read(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    logic [7:0] b;
    int t, tp;
    fork
      begin send_byte(8'h02, 1'b1); send_word(a); end
      begin
        wait_mv(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rd_mvalid: got %b want 1", ok); end
        vectors++; if (m_address !== a) begin miscompares++; $display("FAIL rd_addr: got %h want %h", m_address, a); end
        vectors++; if (m_wstrb !== 4'h0) begin miscompares++; $display("FAIL rd_wstrb: got %h want 0", m_wstrb); end
        tick(4);
        m_rdata = d;
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL rd_start_bit: got %b want 0", txd); end
        tp = -1;
        for (int k = 0; k < 4; k++) begin
          recv_byte(b, t);
          vectors++; if (b !== d[8*k +: 8]) begin miscompares++; $display("FAIL rd_byte%0d: got %h want %h", k, b, d[8*k +: 8]); end
          if (k > 0) begin
            vectors++; if (t - tp !== 80) begin miscompares++; $display("FAIL rd_spacing%0d: got %0d want 80", k, t - tp); end
          end
          tp = t;
        end
        tick(3);
        vectors++; if (rts !== 1'b0) begin miscompares++; $display("FAIL rd_rts_stop: got %b want 0", rts); end
        tick(1);
        vectors++; if (rts !== 1'b1) begin miscompares++; $display("FAIL rd_rts_idle: got %b want 1", rts); end
      end
    join
    m_rdata = '0;
    tick(10);
  endtask

  task automatic test_bad_cmd;
    logic [7:0] b;
    int t, mv0;
    mv0 = mv_rises;
    fork
      send_byte(8'h7F, 1'b1);
      recv_byte(b, t);
    join
    tick(10);
    vectors++; if (b !== 8'h15) begin miscompares++; $display("FAIL bad_nak: got %h want 15", b); end
    vectors++; if (mv_rises !== mv0) begin miscompares++; $display("FAIL bad_no_txn: got %0d want %0d", mv_rises, mv0); end
    test_write(32'h0000_0104, 32'h0BAD_F00D);
  endtask

  task automatic test_frame_err;
    int f0, mv0;
    f0 = ferr_cnt;
    mv0 = mv_rises;
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b0);
    tick(16);
    vectors++; if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
    vectors++; if (mv_rises !== mv0) begin miscompares++; $display("FAIL ferr_no_txn: got %0d want %0d", mv_rises, mv0); end
    vectors++; if (rts !== 1'b1) begin miscompares++; $display("FAIL ferr_rts: got %b want 1", rts); end
    test_read(32'h0000_0024, 32'h89AB_CDEF);
  endtask

  task automatic test_flow_ctrl;
    logic ok, bad;
    logic [7:0] b;
    int t;
    cts = 1'b0;
    fork
      begin send_byte(8'h01, 1'b1); send_word(32'h40); send_word(32'h1234_5678); end
      begin
        wait_mv(ok);
        tick(1);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
          if (txd !== 1'b1 || rts !== 1'b0) bad = 1'b1;
          tick(1);
        end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL flow_hold: got %b want 0", bad); end
        cts = 1'b1;
        tick(1);
        vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL flow_start: got %b want 0", txd); end
        recv_byte(b, t);
        vectors++; if (b !== 8'h06) begin miscompares++; $display("FAIL flow_ack: got %h want 06", b); end
      end
    join
    tick(10);
  endtask

  task automatic test_reset_mid;
    logic ok;
    fork
      begin send_byte(8'h02, 1'b1); send_word(32'h30); end
      begin
        wait_mv(ok);
        m_rdata = 32'h1122_3344;
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        tick(20);
        rst = 1'b0;
        tick(1);
        vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL mid_txd: got %b want 1", txd); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_mvalid: got %b want 0", m_valid); end
        vectors++; if (rts !== 1'b0) begin miscompares++; $display("FAIL mid_rts: got %b want 0", rts); end
        rst = 1'b1;
        tick(1);
        vectors++; if (rts !== 1'b1) begin miscompares++; $display("FAIL mid_rts_rise: got %b want 1", rts); end
      end
    join
    m_rdata = '0;
    tick(10);
    test_write(32'hA5A5_0008, 32'h5A5A_C3C3);
  endtask

  initial begin
    test_reset();
    tick(5);
    test_write(32'h0000_0010, 32'hDEAD_BEEF);
    test_read(32'h0000_0020, 32'hCAFE_F00D);
    test_bad_cmd();
    test_frame_err();
    test_flow_ctrl();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
